// File: rtl/axi_lite_write_arbiter_pkg.sv
// Shared types and elaboration-time helpers for the AXI-lite write arbiter.
package axi_lite_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Low bit of requester idx's field inside a packed per-requester bus.
   function automatic int slice_base(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/axi_lite_write_arbiter_if.sv
// Write-port bundle between the arbiter and the downstream axi_lite_master.
interface axi_lite_write_arbiter_if #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32
);
   logic [AXI_ADDR_WIDTH-1:0]   waddr;
   logic [AXI_DATA_WIDTH-1:0]   wdata;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                        write;
   logic                        full;

   modport master (output waddr, output wdata, output wstrb, output write, input full);
   modport slave  (input waddr, input wdata, input wstrb, input write, output full);
endinterface

// File: rtl/axi_lite_write_arbiter_rr_arbiter.sv
// Round-robin picker: first set request strictly after ptr_i, wrapping around.
module rr_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o
);

   logic [N-1:0]   gt_mask;
   logic [2*N-1:0] dbl_req;
   logic [2*N-1:0] dbl_iso;

   // Upper copy holds the wrapped requests, so the lowest set bit of the
   // doubled vector is the next requester in round-robin order.
   always_comb begin
      gt_mask = '0;
      for (int i = 0; i < N; i++) begin
         gt_mask[i] = (i > int'(ptr_i));
      end
      dbl_req = {req_i, req_i & gt_mask};
      dbl_iso = dbl_req & (~dbl_req + (2*N)'(1));
      grant_o = dbl_iso[N-1:0] | dbl_iso[2*N-1:N];
      idx_o   = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_o[i]) begin
            idx_o = IW'(i);
         end
      end
   end

endmodule

// File: rtl/axi_lite_write_arbiter.sv
// Shares one axi_lite_master write port among NUM_REQ requesters with
// round-robin per beat, optional multi-beat locks and a lock watchdog.
module axi_lite_write_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int LOCK_TIMEOUT   = 256
) (
   input  logic                                  aclk,
   input  logic                                  areset,
   input  logic [NUM_REQ-1:0]                    req_valid_i,
   input  logic [NUM_REQ-1:0]                    req_last_i,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]     req_waddr_i,
   input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]     req_wdata_i,
   input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0]   req_wstrb_i,
   output logic [NUM_REQ-1:0]                    req_ready_o,
   axi_lite_write_arbiter_if.master              m_if,
   output logic [NUM_REQ-1:0]                    grant_o,
   output logic [NUM_REQ-1:0]                    lock_abort_o,
   input  logic                                  abort_clear_i
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int IDX_W  = max_int(1, clog2(NUM_REQ));
   localparam int TMR_W  = max_int(1, clog2(LOCK_TIMEOUT + 1));
   localparam bit WDOG_EN = (LOCK_TIMEOUT != 0);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
   localparam logic [TMR_W-1:0] TMR_MAX  = '1;

   arb_state_e                state_q, state_d;
   logic [IDX_W-1:0]          ptr_q, ptr_d;
   logic [IDX_W-1:0]          owner_q, owner_d;
   logic [TMR_W-1:0]          timer_q, timer_d;
   logic                      out_valid_q, out_valid_d;
   logic [AXI_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic [AXI_DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [STRB_W-1:0]         out_strb_q, out_strb_d;
   logic [NUM_REQ-1:0]        grant_q, grant_d;
   logic [NUM_REQ-1:0]        abort_q, abort_d;

   logic                      write_en;
   logic                      load_en;
   logic [NUM_REQ-1:0]        arb_grant;
   logic [IDX_W-1:0]          arb_idx;
   logic [IDX_W-1:0]          sel_idx;
   logic [NUM_REQ-1:0]        ready;
   logic [NUM_REQ-1:0]        abort_set;
   logic [AXI_ADDR_WIDTH-1:0] sel_addr;
   logic [AXI_DATA_WIDTH-1:0] sel_data;
   logic [STRB_W-1:0]         sel_strb;

   rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
      .req_i   (req_valid_i),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   // The output register may refill in the same cycle the master drains it.
   assign write_en = out_valid_q & ~m_if.full;
   assign load_en  = ~out_valid_q | write_en;

   assign sel_idx  = (state_q == ST_LOCKED) ? owner_q : arb_idx;
   assign sel_addr = req_waddr_i[slice_base(int'(sel_idx), AXI_ADDR_WIDTH) +: AXI_ADDR_WIDTH];
   assign sel_data = req_wdata_i[slice_base(int'(sel_idx), AXI_DATA_WIDTH) +: AXI_DATA_WIDTH];
   assign sel_strb = req_wstrb_i[slice_base(int'(sel_idx), STRB_W) +: STRB_W];

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      timer_d     = timer_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_strb_d  = out_strb_q;
      grant_d     = grant_q;
      ready       = '0;
      abort_set   = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (load_en && (|req_valid_i)) begin
               ready = arb_grant;
               if (req_last_i[arb_idx]) begin
                  ptr_d = arb_idx;
               end else begin
                  state_d = ST_LOCKED;
                  owner_d = arb_idx;
                  timer_d = '0;
               end
            end
         end
         ST_LOCKED: begin
            // Only cycles where the owner itself is silent count toward the watchdog.
            if (req_valid_i[owner_q]) begin
               if (load_en) begin
                  ready[owner_q] = 1'b1;
                  timer_d        = '0;
                  if (req_last_i[owner_q]) begin
                     state_d = ST_IDLE;
                     ptr_d   = owner_q;
                  end
               end
            end else if (WDOG_EN && (timer_q == TMR_LAST)) begin
               state_d            = ST_IDLE;
               ptr_d              = owner_q;
               abort_set[owner_q] = 1'b1;
            end else if (timer_q != TMR_MAX) begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_en) begin
         out_valid_d = |ready;
         if (|ready) begin
            out_addr_d = sel_addr;
            out_data_d = sel_data;
            out_strb_d = sel_strb;
            grant_d    = ready;
         end
      end

      abort_d = (abort_clear_i ? '0 : abort_q) | abort_set;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= IDX_W'(NUM_REQ - 1);
         owner_q     <= '0;
         timer_q     <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_strb_q  <= '0;
         grant_q     <= '0;
         abort_q     <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         timer_q     <= timer_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_strb_q  <= out_strb_d;
         grant_q     <= grant_d;
         abort_q     <= abort_d;
      end
   end

   assign req_ready_o  = ready;
   assign grant_o      = grant_q;
   assign lock_abort_o = abort_q;
   assign m_if.waddr   = out_addr_q;
   assign m_if.wdata   = out_data_q;
   assign m_if.wstrb   = out_strb_q;
   assign m_if.write   = write_en;

endmodule
